// File: rtl/fifo_gray_pkg.sv
// Shared constants and width-generic Gray/binary conversions for the
// dual-clock FIFO pointer logic.
package fifo_gray_pkg;

  localparam int unsigned MODE_WRITE = 0;
  localparam int unsigned MODE_READ  = 1;

  // Widest pointer supported: ADDR_WIDTH up to 15 gives 16-bit pointers.
  localparam int unsigned PTR_MAX_W  = 16;

  // Binary to Gray over the low 'width' bits; bits at or above 'width' are forced to 0.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin,
                                                    input int unsigned          width);
    logic [PTR_MAX_W-1:0] shifted;
    logic [PTR_MAX_W-1:0] gray;
    shifted = bin >> 1;
    gray    = '0;
    for (int unsigned i = 0; i < PTR_MAX_W; i++) begin
      if (i < width) begin
        gray[i] = bin[i] ^ ((i + 1 < width) ? shifted[i] : 1'b0);
      end
    end
    return gray;
  endfunction

  // Gray to binary as a prefix XOR from the MSB down, valid for any width.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray,
                                                    input int unsigned          width);
    logic [PTR_MAX_W-1:0] bin;
    logic                 acc;
    int unsigned          idx;
    bin = '0;
    acc = 1'b0;
    for (int unsigned k = 0; k < PTR_MAX_W; k++) begin
      idx = PTR_MAX_W - 1 - k;
      if (idx < width) begin
        acc      = acc ^ gray[idx];
        bin[idx] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser chain with synchronous reset to zero.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_gray_ptr.sv
// One side of an async FIFO: local binary/Gray pointer, synchronised remote
// pointer, and registered full/empty flag plus occupancy level.
module fifo_gray_ptr
  import fifo_gray_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   remote_ptr_gray,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  flag,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned     PTR_W     = ADDR_WIDTH + 1;
  // Full when the local Gray pointer equals the remote one with its top two bits inverted.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_WIDTH - 1);
  localparam logic            RST_FLAG  = (MODE == MODE_READ);

  logic [PTR_W-1:0] ptr_bin;
  logic [PTR_W-1:0] ptr_bin_next;
  logic [PTR_W-1:0] ptr_gray_next;
  logic [PTR_W-1:0] rsync;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_next;
  logic             flag_next;
  logic             accept;

  sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_remote_sync (
    .clk (clk),
    .rst (rst),
    .d   (remote_ptr_gray),
    .q   (rsync)
  );

  // Next pointer, flag and level; the flag sees the advanced pointer so it never lags an accept.
  always_comb begin
    accept        = inc && !flag;
    ptr_bin_next  = ptr_bin + PTR_W'(accept);
    ptr_gray_next = PTR_W'(bin2gray(PTR_MAX_W'(ptr_bin_next), PTR_W));
    rbin          = PTR_W'(gray2bin(PTR_MAX_W'(rsync), PTR_W));
    flag_next     = RST_FLAG;
    level_next    = '0;
    if (MODE == MODE_WRITE) begin
      flag_next  = (ptr_gray_next == (rsync ^ FULL_MASK));
      level_next = ptr_bin_next - rbin;
    end else begin
      flag_next  = (ptr_gray_next == rsync);
      level_next = rbin - ptr_bin_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      flag     <= RST_FLAG;
      level    <= '0;
    end else begin
      ptr_bin  <= ptr_bin_next;
      ptr_gray <= ptr_gray_next;
      flag     <= flag_next;
      level    <= level_next;
    end
  end

  assign addr = ptr_bin[ADDR_WIDTH-1:0];

endmodule
